dm_handshake_mem: RTL and testbench
===================================

// Module: dm_handshake_mem
// PURPOSE
//  Parametrised data memory for the multi-cycle/pipelined CPU data port.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Returns the response after a programmable number of wait cycles.
//  Supports word, half and byte access with load sign/zero extension.
//  Flags misaligned and out-of-range accesses instead of silently aliasing them.
// PARAMETERS
//  DEPTH      1024   number of 32-bit words (power of two, >=4); AW=$clog2(DEPTH)
//  ADDR_BASE  32'h0  byte address of word 0 (word aligned)
//  LATENCY    1      cycles from request accept to resp_valid (>=1)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept (high only in IDLE)
//  req_we      in   1   1=store, 0=load
//  req_type    in   3   access type: DM_w, DM_h, DM_hu, DM_b, DM_bu codes from const.v
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; h uses [15:0], b uses [7:0]
//  req_pc      in   32  PC of the issuing instruction (store trace only)
//  resp_valid  out  1   response available
//  resp_ready  in   1   consumer takes response
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  2   0=ok, 1=misaligned, 2=out of range, 3=bad type
// BEHAVIOUR
//  Reset:
//   - All memory words are cleared in one cycle.
//   - State goes to IDLE, which aborts any in-flight request with no response.
//   - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//  Accept: a request is accepted on the rising edge where req_valid & req_ready.
//   - All request fields are sampled on that edge.
//   - Store write and load read both happen on that edge.
//   - Load data is captured into the response register on that edge.
//  Error checks (priority: bad type > misaligned > range):
//   - Bad type: a store with DM_hu/DM_bu, or any unknown code.
//   - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//   - Out of range: off=addr-ADDR_BASE, error if off>=4*DEPTH; unsigned, so addr<ADDR_BASE is also out of range.
//   - On error: no memory write, resp_rdata=0.
//  Indexing: word index off[AW+1:2].
//   - Half lane = off[1] (0 -> bits 15:0, 1 -> bits 31:16).
//   - Byte lane = off[1:0] (0 -> bits 7:0, ... 3 -> bits 31:24).
//   - Stores modify only the addressed lanes.
//  Load extension:
//   - h: sign-extend bit 15 of the lane; hu: zero-extend.
//   - b: sign-extend bit 7 of the lane; bu: zero-extend.
//  FSM:
//   - IDLE: on accept, cnt<=LATENCY-1; go to RESP if LATENCY==1, else WAIT.
//   - WAIT: cnt decrements each cycle; go to RESP when cnt reaches 1.
//   - RESP: resp_valid=1, resp_rdata/resp_err held stable.
//     On resp_valid & resp_ready, go to IDLE.
//  Timing:
//   - Accept at edge N gives resp_valid high from N+LATENCY.
//   - req_ready rises the cycle after the response handshake.
//   - Back-to-back throughput: one request per LATENCY+1 cycles.
//  Holding: resp_ready low holds RESP indefinitely; outputs are unchanged and no new request is accepted.
//  Reset priority: reset asserted in WAIT/RESP wins over the handshake.
//   - A store accepted before reset is undone by the clear.
//  Trace: every successful store prints $display("@%h: *%h <= %h", pc, addr, wdata).
//   - Erroring stores print nothing.
// TESTING
//  1. LATENCY=1: store w 0x12345678 @0x10, then load w @0x10
//     -> resp_valid 1 cycle after accept, rdata=0x12345678, err=0.
//  2. Store b 0x80 @0x13, then load b @0x13 -> 0xFFFFFF80; load bu -> 0x00000080;
//     load w @0x10 -> 0x80345678.
//  3. Store h 0xBEEF @0x22, then load h @0x22 -> 0xFFFFBEEF; load hu -> 0x0000BEEF;
//     load h @0x21 -> err=1, rdata=0.
//  4. DEPTH=16, ADDR_BASE=0x100: store @0x140 -> err=2, memory unchanged;
//     load @0xFC -> err=2.
//  5. LATENCY=4, resp_ready held low 3 extra cycles
//     -> resp_valid at accept+4, held stable, req_ready=0 throughout;
//     next accept possible 1 cycle after the handshake.
//  6. Reset asserted in WAIT after a store to 0x0
//     -> resp_valid never rises, req_ready=1 next cycle, load @0x0 returns 0.

Source files
------------

// File: rtl/dm_handshake_mem.sv
// Data memory for the CPU data port: one load/store at a time over valid/ready,
// response after LATENCY cycles, word/half/byte lanes with load extension,
// and explicit error codes for bad type, misalignment and out-of-range access.
module dm_handshake_mem #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;

  // Access type codes, matching the RISC-V funct3 encoding used by the core
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_TYPE  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           req_ready_q;
  logic           resp_valid_q;
  logic [31:0]    resp_rdata_q;
  logic [1:0]     resp_err_q;

  logic [31:0]    mem_q [DEPTH];

  logic [31:0]    off;
  logic [AW-1:0]  word_idx;
  logic [31:0]    rd_word;
  logic [31:0]    wr_word;
  logic [31:0]    load_data;
  logic [15:0]    half_v;
  logic [7:0]     byte_v;
  logic           bad_type;
  logic           misaligned;
  logic           out_of_range;
  logic [1:0]     err_d;
  logic [31:0]    rdata_d;
  logic           accept;
  logic           do_write;

  // The PC only feeds the simulation store trace, which lives outside this RTL
  logic unused_pc;
  assign unused_pc = ^req_pc;

  assign accept   = req_valid & req_ready_q;
  assign do_write = accept & req_we & (err_d == ERR_OK);

  // Decode the request: lane select, load extension, merged store word, error code
  always_comb begin
    off          = req_addr - ADDR_BASE;
    word_idx     = off[AW+1:2];
    rd_word      = mem_q[word_idx];
    wr_word      = rd_word;
    load_data    = '0;
    half_v       = off[1] ? rd_word[31:16] : rd_word[15:0];
    byte_v       = rd_word[{off[1:0], 3'b000} +: 8];
    bad_type     = 1'b0;
    misaligned   = 1'b0;
    case (req_type)
      DM_W: begin
        misaligned = (off[1:0] != 2'b00);
        load_data  = rd_word;
        wr_word    = req_wdata;
      end
      DM_H, DM_HU: begin
        misaligned = off[0];
        bad_type   = req_we & (req_type == DM_HU);
        load_data  = {{16{half_v[15] & (req_type == DM_H)}}, half_v};
        if (off[1]) wr_word[31:16] = req_wdata[15:0];
        else        wr_word[15:0]  = req_wdata[15:0];
      end
      DM_B, DM_BU: begin
        bad_type  = req_we & (req_type == DM_BU);
        load_data = {{24{byte_v[7] & (req_type == DM_B)}}, byte_v};
        wr_word[{off[1:0], 3'b000} +: 8] = req_wdata[7:0];
      end
      default: bad_type = 1'b1;
    endcase
    // Unsigned offset: addresses below the base wrap to huge values and fail too
    out_of_range = ({32'h0, off} >= (64'(DEPTH) << 2));
    if (bad_type)          err_d = ERR_TYPE;
    else if (misaligned)   err_d = ERR_ALIGN;
    else if (out_of_range) err_d = ERR_RANGE;
    else                   err_d = ERR_OK;
    rdata_d = (!req_we && err_d == ERR_OK) ? load_data : 32'h0;
  end

  // Storage array: cleared on reset, written on accepted error-free stores
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_write) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  // Handshake FSM with latency counter and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
            cnt_q        <= CW'(LATENCY - 1);
            req_ready_q  <= 1'b0;
            if (LATENCY == 1) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_handshake_mem.sv
// Bench for dm_handshake_mem: two instances (1 KiW/base 0/latency 1 and
// 16 W/base 0x100/latency 4) driven by directed and random requests, checked
// against a byte-addressed reference memory.
module tb_dm_handshake_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_type   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] req_pc     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_err   [2];

  int errors = 0;
  int checks = 0;

  // Reference memory, one byte per entry, little-endian
  logic [7:0] mbytes [2][4096];

  dm_handshake_mem #(.DEPTH(1024), .ADDR_BASE(32'h0), .LATENCY(1)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_type(req_type[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_pc(req_pc[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dm_handshake_mem #(.DEPTH(16), .ADDR_BASE(32'h100), .LATENCY(4)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_type(req_type[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_pc(req_pc[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int bytes_of(input int d);
    return (d == 0) ? 4096 : 64;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'h100;
  endfunction

  task automatic check(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL d%0d %s: observed=%h expected=%h", d, tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < 4096; i++) mbytes[d][i] = 8'h00;
  endtask

  // Reference behaviour: size/sign from the type code, then the error rules, then the byte access
  task automatic model_access(input int d, input logic we, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] pc,
                              output logic [1:0] err, output logic [31:0] rd);
    int size;
    logic sgn;
    logic [31:0] off;
    size = 0;
    sgn  = 1'b0;
    rd   = 32'h0;
    case (typ)
      3'd2: size = 4;
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd5: size = 2;
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd4: size = 1;
      default: size = 0;
    endcase
    off = addr - base_of(d);
    if (size == 0 || (we && !sgn && size < 4)) err = 2'd3;
    else if ((addr % size) != 0)               err = 2'd1;
    else if (off >= 32'(bytes_of(d)))           err = 2'd2;
    else begin
      err = 2'd0;
      if (we) begin
        for (int i = 0; i < size; i++) mbytes[d][off + i] = wdata[8*i +: 8];
        $display("@%h: *%h <= %h", pc, addr, wdata);
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = mbytes[d][off + i];
        if (sgn && rd[8*size-1]) rd = rd | ~((32'h1 << (8*size)) - 32'h1);
      end
    end
  endtask

  // One full transaction; starts and ends on a falling edge so back-to-back calls run at full rate
  task automatic xact(input int d, input logic we, input logic [2:0] typ,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    logic [31:0] pc;
    int k;
    pc = 32'h400 + 32'($urandom_range(0, 255) * 4);
    model_access(d, we, typ, addr, wdata, pc, e_err, e_rd);
    $display("d%0d %s type=%0d addr=%h wdata=%h hold=%0d -> err=%0d rdata=%h",
             d, we ? "ST" : "LD", typ, addr, wdata, hold, e_err, e_rd);
    check(d, "req_ready idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_type[d] = typ;
    req_addr[d] = addr; req_wdata[d] = wdata; req_pc[d] = pc;
    resp_ready[d] = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b0;
    k = 0;
    while (resp_valid[d] !== 1'b1 && k < 20) begin
      check(d, "req_ready busy", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      k++;
    end
    check(d, "latency", 32'(k), 32'(lat_of(d) - 1));
    check(d, "rdata", resp_rdata[d], e_rd);
    check(d, "err", 32'(resp_err[d]), 32'(e_err));
    check(d, "req_ready in resp", 32'(req_ready[d]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check(d, "hold valid", 32'(resp_valid[d]), 32'd1);
      check(d, "hold rdata", resp_rdata[d], e_rd);
      check(d, "hold err", 32'(resp_err[d]), 32'(e_err));
      check(d, "hold req_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check(d, "valid after handshake", 32'(resp_valid[d]), 32'd0);
    check(d, "req_ready after handshake", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    logic [2:0]  rtyp;
    logic [31:0] raddr;
    int          sz;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_type[d] = 3'd0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_pc[d] = 32'h0; resp_ready[d] = 1'b0;
      model_clear(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check(d, "reset req_ready", 32'(req_ready[d]), 32'd1);
      check(d, "reset resp_valid", 32'(resp_valid[d]), 32'd0);
      check(d, "reset rdata", resp_rdata[d], 32'h0);
      check(d, "reset err", 32'(resp_err[d]), 32'd0);
      reset[d] = 1'b0;
    end
    @(negedge clk);

    // Word store/load, then byte and half lanes with extension
    xact(0, 1'b1, 3'd2, 32'h10, 32'h12345678, 0);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, 0);
    xact(0, 1'b1, 3'd0, 32'h13, 32'h00000080, 0);
    xact(0, 1'b0, 3'd0, 32'h13, 32'h0, 0);
    xact(0, 1'b0, 3'd4, 32'h13, 32'h0, 0);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, 0);
    xact(0, 1'b1, 3'd1, 32'h22, 32'h0000BEEF, 0);
    xact(0, 1'b0, 3'd1, 32'h22, 32'h0, 0);
    xact(0, 1'b0, 3'd5, 32'h22, 32'h0, 0);
    xact(0, 1'b0, 3'd1, 32'h21, 32'h0, 0);
    xact(0, 1'b1, 3'd5, 32'h24, 32'h1111, 0);
    xact(0, 1'b0, 3'd7, 32'h24, 32'h0, 0);

    // Range checks around a non-zero base, and a held response at latency 4
    xact(1, 1'b1, 3'd2, 32'h140, 32'hDEADBEEF, 0);
    xact(1, 1'b0, 3'd2, 32'hFC, 32'h0, 0);
    xact(1, 1'b1, 3'd2, 32'h13C, 32'hCAFEF00D, 3);
    xact(1, 1'b0, 3'd2, 32'h13C, 32'h0, 3);
    xact(1, 1'b0, 3'd2, 32'h100, 32'h0, 1);

    // Random traffic
    for (int n = 0; n < 120; n++) begin
      int d;
      d = n % 2;
      rtyp = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 4))
          0: rtyp = 3'd0; 1: rtyp = 3'd1; 2: rtyp = 3'd2; 3: rtyp = 3'd4; default: rtyp = 3'd5;
        endcase
      end
      raddr = base_of(d) + 32'($urandom_range(0, (d == 0) ? 255 : 63));
      sz = (rtyp == 3'd2) ? 4 : (rtyp == 3'd1 || rtyp == 3'd5) ? 2 : 1;
      if ($urandom_range(0, 9) < 8) raddr = raddr & ~32'(sz - 1);
      if ($urandom_range(0, 9) == 0)
        raddr = ($urandom_range(0, 1) == 0) ? base_of(d) - 32'd4 : base_of(d) + 32'(bytes_of(d));
      xact(d, 1'($urandom_range(0, 1)), rtyp, raddr, $urandom, $urandom_range(0, 2));
    end

    // Reset during the wait phase aborts the store and clears the memory
    xact(1, 1'b1, 3'd2, 32'h100, 32'hA5A5A5A5, 0);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_type[1] = 3'd2;
    req_addr[1] = 32'h100; req_wdata[1] = 32'h5A5A5A5A; req_pc[1] = 32'h800;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check(1, "wait valid low", 32'(resp_valid[1]), 32'd0);
    reset[1] = 1'b1;
    model_clear(1);
    $display("d1 reset during WAIT");
    @(negedge clk);
    reset[1] = 1'b0;
    check(1, "post-reset req_ready", 32'(req_ready[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check(1, "post-reset valid", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
    end
    xact(1, 1'b0, 3'd2, 32'h100, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
